// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C host scheduler: FSM state encoding,
// quarter-phase numbering and the per-state SCL/SDA drive pattern.
package i2c_pkg;

  localparam int DEFAULT_CLK_DIV = 125;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARB,
    ST_START,
    ST_TXBYTE,
    ST_TXACK,
    ST_RXBYTE,
    ST_MNACK,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } state_t;

  // Returns {scl, sda_oe} for a given state and quarter; sda_oe=1 pulls SDA low.
  function automatic logic [1:0] bus_drive(state_t st, logic [1:0] q, logic tx_bit);
    logic slot_scl;
    slot_scl = (q == Q1) || (q == Q2);
    case (st)
      ST_START:                      bus_drive = {q != Q3, q != Q0};
      ST_TXBYTE:                     bus_drive = {slot_scl, ~tx_bit};
      ST_TXACK, ST_RXBYTE, ST_MNACK: bus_drive = {slot_scl, 1'b0};
      ST_STOP:                       bus_drive = {q != Q0, q != Q3};
      default:                       bus_drive = 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Divides clk into SCL quarter ticks and counts the quarter within a bit slot.
// A restart zeroes both counters so the next cycle begins quarter Q0.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart_i,
  input  logic       en_i,
  output logic       tick_o,
  output logic [1:0] qtr_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [1:0]    qtr_q;

  assign tick_o = en_i && !restart_i && (cnt_q == LAST);
  assign qtr_o  = qtr_q;

  always_ff @(posedge clk) begin
    if (rst || restart_i) begin
      cnt_q <= '0;
      qtr_q <= Q0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_q <= '0;
        qtr_q <= qtr_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_host_scheduler.sv
// Two-requester I2C register read/write host with round-robin arbitration.
// SCL/SDA are registered and set one quarter ahead so each quarter starts on its tick.
module i2c_host_scheduler
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV  = DEFAULT_CLK_DIV,
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_rw,
  input  logic [15:0] req_reg_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [7:0]  rdata,
  output logic        nack,
  output logic        busy,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic [3:0]  dbg_state
);

  // Handshake: a requester holds req_valid until its done bit; grant and done
  // are single-cycle pulses, and inputs are captured only in the grant cycle.

  state_t     state_q, state_d;
  logic [1:0] bidx_q, bidx_d;     // 0: addr+W, 1: register, 2: wdata, 3: addr+R
  logic [2:0] bit_q, bit_d;
  logic [7:0] rx_q, rx_d;
  logic       abort_q, abort_d;
  logic       last_q, sel_q, rw_q;
  logic [7:0] reg_q, wdata_q;
  logic [1:0] grant_q, done_q;
  logic [7:0] rdata_q;
  logic       nack_q, busy_q, scl_q, sda_oe_q;
  logic       scl_d, sda_oe_d;

  logic       tick, win, slot_end, sample, tx_bit;
  logic [1:0] qtr, nq;
  logic [7:0] tx_byte;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .restart_i(|grant_q),
    .en_i     (busy_q),
    .tick_o   (tick),
    .qtr_o    (qtr)
  );

  // Requester 1 wins a tie only if requester 0 was served last.
  assign win      = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign slot_end = tick && (qtr == Q3);
  assign sample   = tick && (qtr == Q2);

  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    bit_d   = bit_q;
    rx_d    = rx_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: if (|req_valid) state_d = ST_ARB;
      ST_ARB: begin
        state_d = ST_START;
        bidx_d  = 2'd0;
        bit_d   = 3'd0;
        rx_d    = 8'h00;
        abort_d = 1'b0;
      end
      ST_START: if (slot_end) begin
        state_d = ST_TXBYTE;
        bit_d   = 3'd0;
      end
      ST_TXBYTE: if (slot_end) begin
        if (bit_q == 3'd7) state_d = ST_TXACK;
        bit_d = bit_q + 3'd1;
      end
      ST_TXACK: begin
        if (sample && sda_i) abort_d = 1'b1;
        if (slot_end) begin
          bit_d = 3'd0;
          if (abort_q) state_d = ST_STOP;
          else begin
            case (bidx_q)
              2'd0: begin state_d = ST_TXBYTE; bidx_d = 2'd1; end
              2'd1: begin
                if (rw_q) state_d = ST_STOP;
                else begin state_d = ST_TXBYTE; bidx_d = 2'd2; end
              end
              2'd2:    state_d = ST_STOP;
              default: state_d = ST_RXBYTE;
            endcase
          end
        end
      end
      ST_RXBYTE: begin
        if (sample) rx_d = {rx_q[6:0], sda_i};
        if (slot_end) begin
          if (bit_q == 3'd7) state_d = ST_MNACK;
          bit_d = bit_q + 3'd1;
        end
      end
      ST_MNACK: if (slot_end) state_d = ST_STOP;
      ST_STOP: if (slot_end) begin
        state_d = (!abort_q && rw_q && bidx_q == 2'd1) ? ST_GAP : ST_DONE;
      end
      ST_GAP: if (slot_end) begin
        state_d = ST_START;
        bidx_d  = 2'd3;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (bidx_d)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = reg_q;
      2'd2:    tx_byte = wdata_q;
      default: tx_byte = {DEV_ADDR, 1'b1};
    endcase
    tx_bit = tx_byte[3'd7 - bit_d];
    nq     = (state_q == ST_ARB) ? Q0 : (tick ? qtr + 2'd1 : qtr);
    {scl_d, sda_oe_d} = bus_drive(state_d, nq, tx_bit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bidx_q   <= 2'd0;
      bit_q    <= 3'd0;
      rx_q     <= 8'h00;
      abort_q  <= 1'b0;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      rw_q     <= 1'b0;
      reg_q    <= 8'h00;
      wdata_q  <= 8'h00;
      grant_q  <= 2'b00;
      done_q   <= 2'b00;
      rdata_q  <= 8'h00;
      nack_q   <= 1'b0;
      busy_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bidx_q   <= bidx_d;
      bit_q    <= bit_d;
      rx_q     <= rx_d;
      abort_q  <= abort_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      grant_q  <= 2'b00;
      done_q   <= 2'b00;
      if (state_q == ST_IDLE && |req_valid) begin
        grant_q <= win ? 2'b10 : 2'b01;
        sel_q   <= win;
        last_q  <= win;
        busy_q  <= 1'b1;
        rw_q    <= win ? req_rw[1] : req_rw[0];
        reg_q   <= win ? req_reg_addr[15:8] : req_reg_addr[7:0];
        wdata_q <= win ? req_wdata[15:8] : req_wdata[7:0];
      end
      if (state_q == ST_STOP && state_d == ST_DONE) begin
        done_q  <= sel_q ? 2'b10 : 2'b01;
        nack_q  <= abort_q;
        rdata_q <= (rw_q && !abort_q) ? rx_q : 8'h00;
      end
      if (state_q == ST_DONE) busy_q <= 1'b0;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign nack      = nack_q;
  assign busy      = busy_q;
  assign scl       = scl_q;
  assign sda_oe    = sda_oe_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_host_scheduler.sv
// Bench for i2c_host_scheduler: behavioural I2C slave, bus-event scoreboard,
// grant/done/latency checks, reset and contention scenarios.
module tb_i2c_host_scheduler;

  localparam int         CLK_DIV  = 4;
  localparam logic [6:0] DEV_ADDR = 7'h42;
  localparam logic [9:0] EV_START = 10'h100;
  localparam logic [9:0] EV_STOP  = 10'h101;
  localparam logic [9:0] EV_MNACK = 10'h102;
  localparam logic [9:0] EV_MACK  = 10'h103;
  localparam logic [9:0] EV_NONE  = 10'h3FF;
  localparam int LAT_WR = 1 + 116 * CLK_DIV;
  localparam int LAT_RD = 1 + 164 * CLK_DIV;
  localparam int LAT_AB = 1 + 44 * CLK_DIV;

  logic        clk, rst;
  logic [1:0]  req_valid, req_rw;
  logic [15:0] req_reg_addr, req_wdata;
  logic [1:0]  grant, done;
  logic [7:0]  rdata;
  logic        nack, busy, scl, sda_oe, sda_i;
  logic [3:0]  dbg_state;
  logic        slv_low, sda_line;

  assign sda_line = ~(sda_oe | slv_low);
  assign sda_i    = sda_line;

  logic [9:0]  exp_q[$];
  logic [10:0] res_q[$];
  logic [1:0]  gnt_q[$];
  int          lat_q[$];

  int          n_checks = 0, n_errors = 0;
  int          cyc = 0, last_rise = 0, grant_cyc = 0, done_seen = 0;
  logic        mon_en;
  int          s_cnt;
  logic [7:0]  s_shift, s_rd_byte;
  logic        s_first, s_read, s_rd_pending, s_nack_all;
  logic        prev_scl, prev_sda;

  i2c_host_scheduler #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV_ADDR)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rw      (req_rw),
    .req_reg_addr(req_reg_addr),
    .req_wdata   (req_wdata),
    .grant       (grant),
    .done        (done),
    .rdata       (rdata),
    .nack        (nack),
    .busy        (busy),
    .scl         (scl),
    .sda_oe      (sda_oe),
    .sda_i       (sda_i),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_event(input logic [9:0] ev);
    if (mon_en) begin
      if (exp_q.size() == 0) check("bus_unexpected", ev, EV_NONE);
      else                   check("bus_event", ev, exp_q.pop_front());
    end
  endtask

  // Slave model, bus decoder and grant/done scoreboard
  initial begin
    slv_low = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
    s_cnt = 0; s_shift = 8'h00; s_first = 1'b0; s_read = 1'b0; s_rd_pending = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      s_cnt = 0; s_read = 1'b0; s_first = 1'b0; slv_low = 1'b0;
      prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      if (scl && prev_scl && prev_sda && !sda_line) begin
        bus_event(EV_START);
        s_cnt = 0; s_first = 1'b1; s_read = 1'b0; slv_low = 1'b0;
      end else if (scl && prev_scl && !prev_sda && sda_line) begin
        bus_event(EV_STOP);
        s_cnt = 0; s_read = 1'b0; slv_low = 1'b0;
      end else if (scl && !prev_scl) begin
        if (s_cnt < 8) begin
          s_shift = {s_shift[6:0], sda_line};
          s_cnt++;
          if (s_cnt == 2 && mon_en) check("scl_period", cyc - last_rise, 4 * CLK_DIV);
          if (s_cnt == 8) begin
            bus_event({2'b00, s_shift});
            if (s_first) s_rd_pending = s_shift[0];
          end
        end else begin
          if (s_read) begin
            bus_event(sda_line ? EV_MNACK : EV_MACK);
            s_read = 1'b0;
          end else if (s_first && !sda_line && s_rd_pending) begin
            s_read = 1'b1;
          end
          s_first = 1'b0;
          s_cnt = 0;
        end
        last_rise = cyc;
      end else if (!scl && prev_scl) begin
        if (s_cnt == 8)  slv_low = !s_read && !s_nack_all;
        else if (s_read) slv_low = ~s_rd_byte[7 - s_cnt];
        else             slv_low = 1'b0;
      end
      prev_scl = scl;
      prev_sda = sda_line;

      if (grant != 2'b00) begin
        grant_cyc = cyc;
        check("grant", grant, (gnt_q.size() != 0) ? gnt_q.pop_front() : 2'b00);
        check("busy_at_grant", busy, 1);
      end
      if (done != 2'b00) begin
        done_seen++;
        check("done_nack_rdata", {done, nack, rdata}, (res_q.size() != 0) ? res_q.pop_front() : 11'h0);
        check("busy_at_done", busy, 1);
        if (lat_q.size() != 0) check("latency", cyc - grant_cyc, lat_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic expect_txn(input int idx, input logic rw, input logic [7:0] ra, input logic [7:0] wd,
                            input logic nk, input logic [7:0] rb);
    logic [1:0] oh;
    oh = (idx == 1) ? 2'b10 : 2'b01;
    gnt_q.push_back(oh);
    exp_q.push_back(EV_START);
    exp_q.push_back({2'b00, DEV_ADDR, 1'b0});
    if (nk) begin
      exp_q.push_back(EV_STOP);
      res_q.push_back({oh, 1'b1, 8'h00});
      lat_q.push_back(LAT_AB);
    end else if (!rw) begin
      exp_q.push_back({2'b00, ra});
      exp_q.push_back({2'b00, wd});
      exp_q.push_back(EV_STOP);
      res_q.push_back({oh, 1'b0, 8'h00});
      lat_q.push_back(LAT_WR);
    end else begin
      exp_q.push_back({2'b00, ra});
      exp_q.push_back(EV_STOP);
      exp_q.push_back(EV_START);
      exp_q.push_back({2'b00, DEV_ADDR, 1'b1});
      exp_q.push_back({2'b00, rb});
      exp_q.push_back(EV_MNACK);
      exp_q.push_back(EV_STOP);
      res_q.push_back({oh, 1'b0, rb});
      lat_q.push_back(LAT_RD);
    end
  endtask

  task automatic do_txn(input int idx, input logic rw, input logic [7:0] ra, input logic [7:0] wd,
                        input logic nk, input logic [7:0] rb);
    int t;
    expect_txn(idx, rw, ra, wd, nk, rb);
    s_nack_all = nk;
    s_rd_byte  = rb;
    req_rw[idx] = rw;
    req_reg_addr[idx*8 +: 8] = ra;
    req_wdata[idx*8 +: 8] = wd;
    req_valid[idx] = 1'b1;
    t = 0;
    while (grant[idx] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("grant_wait", t < 50, 1);
    req_reg_addr = 16'($urandom);
    req_wdata    = 16'($urandom);
    req_rw       = 2'($urandom);
    t = 0;
    while (done[idx] !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    check("done_wait", t < 1000, 1);
    req_valid[idx] = 1'b0;
    @(negedge clk);
    check("bus_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scl"}, scl, 1);
    check({tag, "_sda_oe"}, sda_oe, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_nack"}, nack, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int t, seen, ndone;
    rst = 1'b1; req_valid = 2'b00; req_rw = 2'b00;
    req_reg_addr = 16'h0; req_wdata = 16'h0;
    mon_en = 1'b1; s_nack_all = 1'b0; s_rd_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    do_txn(0, 1'b0, 8'h03, 8'hA5, 1'b0, 8'h00);
    do_txn(1, 1'b1, 8'h05, 8'h00, 1'b0, 8'h5A);
    check("rdata_hold", rdata, 8'h5A);
    do_txn(0, 1'b0, 8'h07, 8'h3C, 1'b1, 8'h00);
    check("nack_hold", nack, 1);

    // Reset in the middle of the write-data byte
    mon_en = 1'b0;
    s_nack_all = 1'b0;
    gnt_q.push_back(2'b01);
    req_rw[0] = 1'b0; req_reg_addr[7:0] = 8'h77; req_wdata[7:0] = 8'h99;
    req_valid = 2'b01;
    t = 0;
    while (grant[0] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("rst_grant_wait", t < 50, 1);
    repeat (88 * CLK_DIV) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_state", dbg_state, 4'd3);
    seen = done_seen;
    rst = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("no_done_after_rst", done_seen - seen, 0);
    mon_en = 1'b1;

    // Contention: both held; round-robin must start at requester 0 after reset
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) expect_txn(0, 1'b0, 8'h10, 8'h11, 1'b0, 8'h00);
      else            expect_txn(1, 1'b0, 8'h20, 8'h22, 1'b0, 8'h00);
    end
    req_rw = 2'b00; req_reg_addr = 16'h2010; req_wdata = 16'h2211;
    req_valid = 2'b11;
    ndone = 0; t = 0;
    while (ndone < 4 && t < 4000) begin
      @(negedge clk);
      t++;
      if (done != 2'b00) ndone++;
    end
    req_valid = 2'b00;
    check("contention_dones", ndone, 4);
    @(negedge clk);
    check("contention_drained", exp_q.size(), 0);

    for (int i = 0; i < 3; i++) begin
      do_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 1'b0, 8'($urandom_range(0, 255)));
    end

    repeat (10) @(negedge clk);
    check("queues_empty", gnt_q.size() + res_q.size() + lat_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
